// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - retirement trace FIFO capturing register and memory write events
// Optional dropped-event counter enabled by defining WB_TRACE_DROP_CNT_EN.
module wb_trace_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        grf_we,
   input  logic [4:0]  grf_addr,
   input  logic [31:0] grf_wd,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_kind,
   output logic [31:0] out_pc,
   output logic [31:0] out_addr,
   output logic [31:0] out_data,
   output logic [6:0]  count,
   output logic        overflow,
   output logic        conflict
`ifdef WB_TRACE_DROP_CNT_EN
   ,
   output logic [15:0] drop_cnt
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [6:0]    count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          conflict_q, conflict_d;

   logic          mem_kind_q [DEPTH];
   logic [31:0]   mem_pc_q   [DEPTH];
   logic [31:0]   mem_addr_q [DEPTH];
   logic [31:0]   mem_data_q [DEPTH];

   logic          reg_ev;
   logic          push_req;
   logic          push_kind;
   logic [31:0]   push_addr;
   logic [31:0]   push_data;
   logic          full;
   logic          empty;
   logic          pop;
   logic          push_ok;
   logic          drop;

   // A register write to r0 is architecturally a no-op, so it never competes with dm_we.
   always_comb begin
      reg_ev    = grf_we && (grf_addr != 5'd0);
      push_req  = reg_ev || dm_we;
      push_kind = !reg_ev;
      push_addr = reg_ev ? {27'd0, grf_addr} : dm_addr;
      push_data = reg_ev ? grf_wd : dm_wd;
      full      = (count_q == 7'(DEPTH));
      empty     = (count_q == 7'd0);
      pop       = !empty && out_ready;
      push_ok   = push_req && (!full || pop);
      drop      = push_req && full && !pop;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q || drop;
      conflict_d = conflict_q || (reg_ev && dm_we);
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 7'd1;
         2'b01:   count_d = count_q - 7'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= 7'd0;
         overflow_q <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         conflict_q <= conflict_d;
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_kind_q[wr_ptr_q] <= push_kind;
         mem_pc_q[wr_ptr_q]   <= pc;
         mem_addr_q[wr_ptr_q] <= push_addr;
         mem_data_q[wr_ptr_q] <= push_data;
      end
   end

   always_comb begin
      out_valid = !empty;
      out_kind  = 1'b0;
      out_pc    = 32'd0;
      out_addr  = 32'd0;
      out_data  = 32'd0;
      if (!empty) begin
         out_kind = mem_kind_q[rd_ptr_q];
         out_pc   = mem_pc_q[rd_ptr_q];
         out_addr = mem_addr_q[rd_ptr_q];
         out_data = mem_data_q[rd_ptr_q];
      end
      count    = count_q;
      overflow = overflow_q;
      conflict = conflict_q;
   end

`ifdef WB_TRACE_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_cnt_q <= 16'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb/tb_wb_trace_fifo.sv - directed self-checking bench for wb_trace_fifo
module tb_wb_trace_fifo;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        grf_we;
   logic [4:0]  grf_addr;
   logic [31:0] grf_wd;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wd;
   logic        out_valid;
   logic        out_ready;
   logic        out_kind;
   logic [31:0] out_pc;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [6:0]  count;
   logic        overflow;
   logic        conflict;
`ifdef WB_TRACE_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int total = 0;
   int bad   = 0;

   wb_trace_fifo #(.DEPTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .pc        (pc),
      .grf_we    (grf_we),
      .grf_addr  (grf_addr),
      .grf_wd    (grf_wd),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wd     (dm_wd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_kind  (out_kind),
      .out_pc    (out_pc),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .count     (count),
      .overflow  (overflow),
      .conflict  (conflict)
`ifdef WB_TRACE_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      grf_we   = 1'b0;
      grf_addr = 5'd0;
      grf_wd   = 32'd0;
      dm_we    = 1'b0;
      dm_addr  = 32'd0;
      dm_wd    = 32'd0;
   endtask

   task automatic push_reg(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d);
      pc       = p;
      grf_we   = 1'b1;
      grf_addr = a;
      grf_wd   = d;
      dm_we    = 1'b0;
   endtask

   task automatic push_mem(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
      pc      = p;
      grf_we  = 1'b0;
      dm_we   = 1'b1;
      dm_addr = a;
      dm_wd   = d;
   endtask

   initial begin
      logic [31:0] exp_d;
      reset     = 1'b0;
      pc        = 32'd0;
      out_ready = 1'b0;
      idle();
      #22;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_flags", {30'd0, overflow, conflict}, 32'd0);
      reset = 1'b1;
      tick();

      // Single register write, latency one cycle.
      push_reg(32'h3000, 5'd5, 32'h1234);
      #1;
      chk("no_comb_path", 32'(out_valid), 32'd0);
      tick();
      idle();
      chk("r37_valid", 32'(out_valid), 32'd1);
      chk("r37_kind", 32'(out_kind), 32'd0);
      chk("r37_addr", out_addr, 32'd5);
      chk("r37_data", out_data, 32'h1234);
      chk("r37_pc", out_pc, 32'h3000);
      chk("r37_count", 32'(count), 32'd1);
      tick();
      chk("hold_data", out_data, 32'h1234);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pop_count", 32'(count), 32'd0);
      chk("empty_zero", out_data, 32'd0);

      // r0 write is ignored; simultaneous memory write is recorded without conflict.
      push_mem(32'h3004, 32'h10, 32'hAB);
      grf_we   = 1'b1;
      grf_addr = 5'd0;
      grf_wd   = 32'hFF;
      tick();
      idle();
      chk("r38_count", 32'(count), 32'd1);
      chk("r38_kind", 32'(out_kind), 32'd1);
      chk("r38_addr", out_addr, 32'h10);
      chk("r38_data", out_data, 32'hAB);
      chk("r38_conflict", 32'(conflict), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Fill to 8, then one more is dropped.
      for (int i = 0; i < 9; i++) begin
         push_reg(32'h4000 + 32'(4 * i), 5'(i + 1), 32'd100 + 32'(i));
         tick();
         if (i == 7) begin
            chk("full_count", 32'(count), 32'd8);
            chk("full_no_ovf", 32'(overflow), 32'd0);
         end
      end
      idle();
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_head_data", out_data, 32'd100);
      chk("ovf_head_addr", out_addr, 32'd1);
`ifdef WB_TRACE_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'd1);
`endif

      // Full with simultaneous push and pop.
      push_mem(32'h5000, 32'h20, 32'd200);
      out_ready = 1'b1;
      #1;
      chk("fpp_popped", out_data, 32'd100);
      tick();
      idle();
      chk("fpp_count", 32'(count), 32'd8);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      for (int i = 0; i < 8; i++) begin
         exp_d = (i < 7) ? 32'd101 + 32'(i) : 32'd200;
         chk("drain_data", out_data, exp_d);
         chk("drain_kind", 32'(out_kind), (i < 7) ? 32'd0 : 32'd1);
         tick();
      end
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_valid", 32'(out_valid), 32'd0);
      tick();
      chk("no_underflow", 32'(count), 32'd0);
      out_ready = 1'b0;

      // Mid-cycle reset with 4 entries stored.
      for (int i = 0; i < 4; i++) begin
         push_reg(32'h6000, 5'd9, 32'd300 + 32'(i));
         tick();
      end
      idle();
      chk("pre_rst_count", 32'(count), 32'd4);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_ovf", 32'(overflow), 32'd0);
`ifdef WB_TRACE_DROP_CNT_EN
      chk("arst_drop", 32'(drop_cnt), 32'd0);
`endif
      #2;
      reset = 1'b1;
      tick();

      push_reg(32'h7000, 5'd7, 32'h77);
      tick();
      idle();
      chk("post_rst_count", 32'(count), 32'd1);
      chk("post_rst_data", out_data, 32'h77);

      // Register and memory write together: register wins, conflict sticks.
      push_reg(32'h7004, 5'd3, 32'h33);
      dm_we   = 1'b1;
      dm_addr = 32'h40;
      dm_wd   = 32'h44;
      tick();
      idle();
      chk("r42_count", 32'(count), 32'd2);
      chk("r42_conflict", 32'(conflict), 32'd1);
      push_mem(32'h7008, 32'h80, 32'h88);
      out_ready = 1'b1;
      tick();
      idle();
      out_ready = 1'b0;
      chk("pp_count", 32'(count), 32'd2);
      chk("r42_kind", 32'(out_kind), 32'd0);
      chk("r42_addr", out_addr, 32'd3);
      chk("r42_data", out_data, 32'h33);
      out_ready = 1'b1;
      tick();
      chk("pp_order", out_data, 32'h88);
      tick();
      out_ready = 1'b0;
      chk("final_count", 32'(count), 32'd0);
      chk("conflict_sticky", 32'(conflict), 32'd1);
      reset = 1'b0;
      #1;
      chk("conflict_rst", 32'(conflict), 32'd0);
      reset = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
